// File: rtl/anita3_pps_conditioner.sv
// anita3_pps_conditioner
// Turns the raw, asynchronous GPS PPS into a clean one-clock pulse in the
// clk250_i domain. Each GPS edge is checked against the nominal 1 s period,
// and early glitches are rejected. During GPS dropouts a synthetic PPS keeps
// the downstream timebase advancing.
//
// Ports:
//   clk250_i        sole clock (250 MHz)
//   rst_n_i         async active-low reset, released synchronously inside
//   gps_pps_i       raw GPS PPS, asynchronous, active-high, >= 2 clocks wide
//   gps_en_i        0 masks GPS edges (treated as absent)
//   pps_o           conditioned PPS, exactly one clock high
//   locked_o        state is LOCKED or HOLDOVER
//   holdover_o      state is HOLDOVER
//   last_period_o   period count at the last accepted GPS edge
//   missed_count_o  consecutive synthetic pulses in the current holdover
//   glitch_count_o  early edges rejected since reset, saturating
module anita3_pps_conditioner #(
  parameter int NOMINAL_PERIOD = 250000000,
  parameter int TOLERANCE      = 2500,
  parameter int LOCK_COUNT     = 3,
  parameter int HOLDOVER_MAX   = 16
) (
  input  logic        clk250_i,
  input  logic        rst_n_i,
  input  logic        gps_pps_i,
  input  logic        gps_en_i,
  output logic        pps_o,
  output logic        locked_o,
  output logic        holdover_o,
  output logic [27:0] last_period_o,
  output logic [7:0]  missed_count_o,
  output logic [7:0]  glitch_count_o
);

  localparam logic [27:0] WIN_LO   = 28'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [27:0] WIN_HI   = 28'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [27:0] NOM      = 28'(NOMINAL_PERIOD);
  localparam logic [27:0] CNT_MAX  = 28'hFFF_FFFF;
  localparam logic [3:0]  LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [7:0]  HOLD_MAX = 8'(HOLDOVER_MAX);

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  logic [1:0]  rst_sync_r;
  logic        rst_int_n_s;
  logic [1:0]  pps_sync_r;
  logic        pps_sync_d_r;
  logic        edge_s;
  logic        edge_r;
  logic        edge_ok_s;
  logic [27:0] cnt_r;
  logic [27:0] c_s;
  logic        in_win_s;
  logic        early_s;
  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  g_r;
  logic [3:0]  g_next_s;
  logic [3:0]  g_cand_s;
  logic        pps_r;
  logic        pps_next_s;
  logic        locked_r;
  logic        holdover_r;
  logic [27:0] last_r;
  logic [27:0] last_next_s;
  logic [7:0]  missed_r;
  logic [7:0]  missed_next_s;
  logic [7:0]  missed_inc_s;
  logic [7:0]  glitch_r;
  logic [7:0]  glitch_next_s;
  logic [7:0]  glitch_inc_s;

  // Reset release synchronizer: assert immediately, deassert after two clocks.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Rising edge of the synchronized GPS PPS, gated by the enable.
  assign edge_s    = pps_sync_r[1] & ~pps_sync_d_r & gps_en_i;
  // Guard keeps pps_o from ever being high on two consecutive cycles.
  assign edge_ok_s = edge_r & ~pps_r;

  // cnt_r is 0 on the pps cycle, so c_s equals the spacing from the last
  // pulse to the pulse this cycle would emit; all window checks use c_s.
  assign c_s      = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + 28'd1);
  assign in_win_s = (c_s >= WIN_LO) && (c_s <= WIN_HI);
  assign early_s  = (c_s < WIN_LO);

  assign g_cand_s     = ((g_r == 4'd0) || !in_win_s) ? 4'd1 : (g_r + 4'd1);
  assign missed_inc_s = (missed_r == 8'hFF) ? missed_r : (missed_r + 8'd1);
  assign glitch_inc_s = (glitch_r == 8'hFF) ? glitch_r : (glitch_r + 8'd1);

  // Next-state and next-output decode for acquire / lock / holdover.
  always_comb begin
    state_next_s  = state_r;
    pps_next_s    = 1'b0;
    g_next_s      = g_r;
    last_next_s   = last_r;
    missed_next_s = missed_r;
    glitch_next_s = glitch_r;
    case (state_r)
      ST_ACQUIRE: begin
        if (edge_ok_s) begin
          pps_next_s    = 1'b1;
          last_next_s   = c_s;
          missed_next_s = 8'd0;
          g_next_s      = g_cand_s;
          if (g_cand_s >= LOCK_CNT) begin
            state_next_s = ST_LOCKED;
          end else begin
            state_next_s = ST_ACQUIRE;
          end
        end else begin
          state_next_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (edge_ok_s && in_win_s) begin
          pps_next_s    = 1'b1;
          last_next_s   = c_s;
          missed_next_s = 8'd0;
        end else if (c_s >= WIN_HI) begin
          // GPS overdue: synthetic pulse at the late edge of the window.
          pps_next_s    = 1'b1;
          missed_next_s = 8'd1;
          if (HOLD_MAX <= 8'd1) begin
            state_next_s = ST_ACQUIRE;
            g_next_s     = 4'd0;
          end else begin
            state_next_s = ST_HOLDOVER;
          end
        end else if (edge_ok_s && early_s) begin
          glitch_next_s = glitch_inc_s;
        end else begin
          state_next_s = ST_LOCKED;
        end
      end
      ST_HOLDOVER: begin
        if (edge_ok_s && in_win_s) begin
          pps_next_s    = 1'b1;
          last_next_s   = c_s;
          missed_next_s = 8'd0;
          state_next_s  = ST_LOCKED;
        end else if (c_s >= NOM) begin
          pps_next_s    = 1'b1;
          missed_next_s = missed_inc_s;
          if (missed_inc_s >= HOLD_MAX) begin
            state_next_s = ST_ACQUIRE;
            g_next_s     = 4'd0;
          end else begin
            state_next_s = ST_HOLDOVER;
          end
        end else if (edge_ok_s && early_s) begin
          glitch_next_s = glitch_inc_s;
        end else begin
          state_next_s = ST_HOLDOVER;
        end
      end
      default: begin
        state_next_s = ST_ACQUIRE;
        g_next_s     = 4'd0;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk250_i or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      pps_sync_r   <= 2'b00;
      pps_sync_d_r <= 1'b0;
      edge_r       <= 1'b0;
      cnt_r        <= 28'd0;
      state_r      <= ST_ACQUIRE;
      g_r          <= 4'd0;
      pps_r        <= 1'b0;
      locked_r     <= 1'b0;
      holdover_r   <= 1'b0;
      last_r       <= 28'd0;
      missed_r     <= 8'd0;
      glitch_r     <= 8'd0;
    end else begin
      pps_sync_r   <= {pps_sync_r[0], gps_pps_i};
      pps_sync_d_r <= pps_sync_r[1];
      edge_r       <= edge_s;
      cnt_r        <= pps_next_s ? 28'd0 : c_s;
      state_r      <= state_next_s;
      g_r          <= g_next_s;
      pps_r        <= pps_next_s;
      locked_r     <= (state_next_s != ST_ACQUIRE);
      holdover_r   <= (state_next_s == ST_HOLDOVER);
      last_r       <= last_next_s;
      missed_r     <= missed_next_s;
      glitch_r     <= glitch_next_s;
    end
  end

  assign pps_o          = pps_r;
  assign locked_o       = locked_r;
  assign holdover_o     = holdover_r;
  assign last_period_o  = last_r;
  assign missed_count_o = missed_r;
  assign glitch_count_o = glitch_r;

endmodule

// File: tb/tb_anita3_pps_conditioner.sv
// Directed bench for anita3_pps_conditioner with N=100, T=4, LOCK_COUNT=3,
// HOLDOVER_MAX=4. A GPS pulse raised on the falling edge before rising edge
// k+1 yields pps_o three rising edges later; times are tracked in cycles.
module tb_anita3_pps_conditioner;
  localparam int N  = 100;
  localparam int T  = 4;
  localparam int LC = 3;
  localparam int HM = 4;

  logic        clk250 = 1'b0;
  logic        rst_n;
  logic        gps_pps;
  logic        gps_en;
  logic        pps_o;
  logic        locked_o;
  logic        holdover_o;
  logic [27:0] last_period_o;
  logic [7:0]  missed_count_o;
  logic [7:0]  glitch_count_o;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int pps_cnt = 0;
  int dbl_cnt = 0;
  int exp_l   = 0;
  logic prev_pps = 1'b0;

  anita3_pps_conditioner #(
    .NOMINAL_PERIOD(N),
    .TOLERANCE(T),
    .LOCK_COUNT(LC),
    .HOLDOVER_MAX(HM)
  ) dut (
    .clk250_i(clk250),
    .rst_n_i(rst_n),
    .gps_pps_i(gps_pps),
    .gps_en_i(gps_en),
    .pps_o(pps_o),
    .locked_o(locked_o),
    .holdover_o(holdover_o),
    .last_period_o(last_period_o),
    .missed_count_o(missed_count_o),
    .glitch_count_o(glitch_count_o)
  );

  always #5 clk250 = ~clk250;

  // Cycle counter and pulse monitor, sampled 1 ns after each rising edge.
  always @(posedge clk250) begin
    #1;
    cyc = cyc + 1;
    if (pps_o === 1'b1) begin
      pps_cnt = pps_cnt + 1;
      if (prev_pps === 1'b1) dbl_cnt = dbl_cnt + 1;
    end
    prev_pps = pps_o;
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk250);
  endtask

  task automatic gps_pulse_at(input int n);
    wait_until(n);
    gps_pps = 1'b1;
    repeat (3) @(negedge clk250);
    gps_pps = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gps_pps = 1'b0; gps_en = 1'b1;
    repeat (3) @(negedge clk250);
    checks++;
    if ({pps_o, locked_o, holdover_o} !== 3'b000 || last_period_o !== 28'd0 ||
        missed_count_o !== 8'd0 || glitch_count_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: pps=%b lock=%b hold=%b last=%0d miss=%0d glitch=%0d, required all 0",
               pps_o, locked_o, holdover_o, last_period_o, missed_count_o, glitch_count_o);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk250);
    checks++;
    if (pps_cnt !== 0) begin errors++; $display("FAIL release_no_pps: pulses=%0d, required 0", pps_cnt); end
  endtask

  task automatic test_acquire_lock;
    int r;
    r = cyc + 2;
    gps_pulse_at(r);
    wait_until(r + 3);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL acq_latency_early: pps=%b, required 0", pps_o); end
    wait_until(r + 4);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b0) begin
      errors++; $display("FAIL acq_first: pps=%b lock=%b, required 1 0", pps_o, locked_o);
    end
    exp_l = r + 4;
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b0 || last_period_o !== 28'd100) begin
      errors++; $display("FAIL acq_second: pps=%b lock=%b last=%0d, required 1 0 100", pps_o, locked_o, last_period_o);
    end
    exp_l = exp_l + 100;
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b1 || holdover_o !== 1'b0 || last_period_o !== 28'd100) begin
      errors++; $display("FAIL acq_lock: pps=%b lock=%b hold=%b last=%0d, required 1 1 0 100",
                         pps_o, locked_o, holdover_o, last_period_o);
    end
    exp_l = exp_l + 100;
    wait_until(exp_l + 1);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL acq_single: pps=%b, required 0", pps_o); end
  endtask

  task automatic test_glitch;
    gps_pulse_at(exp_l + 46);
    wait_until(exp_l + 50);
    checks++;
    if (pps_o !== 1'b0 || glitch_count_o !== 8'd1) begin
      errors++; $display("FAIL glitch_reject: pps=%b glitch=%0d, required 0 1", pps_o, glitch_count_o);
    end
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || last_period_o !== 28'd100 || glitch_count_o !== 8'd1) begin
      errors++; $display("FAIL glitch_next_ok: pps=%b last=%0d glitch=%0d, required 1 100 1",
                         pps_o, last_period_o, glitch_count_o);
    end
    exp_l = exp_l + 100;
  endtask

  task automatic test_holdover_expire;
    int n0;
    logic exp_st;
    wait_until(exp_l + 103);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL hold_not_early: pps=%b, required 0", pps_o); end
    wait_until(exp_l + 104);
    checks++;
    if (pps_o !== 1'b1 || holdover_o !== 1'b1 || locked_o !== 1'b1 || missed_count_o !== 8'd1) begin
      errors++; $display("FAIL hold_enter: pps=%b hold=%b lock=%b miss=%0d, required 1 1 1 1",
                         pps_o, holdover_o, locked_o, missed_count_o);
    end
    exp_l = exp_l + 104;
    for (int k = 2; k <= HM; k++) begin
      exp_st = (k < HM) ? 1'b1 : 1'b0;
      wait_until(exp_l + 100);
      checks++;
      if (pps_o !== 1'b1 || missed_count_o !== 8'(k) || holdover_o !== exp_st || locked_o !== exp_st) begin
        errors++; $display("FAIL hold_miss_%0d: pps=%b miss=%0d hold=%b lock=%b, required 1 %0d %b %b",
                           k, pps_o, missed_count_o, holdover_o, locked_o, k, exp_st, exp_st);
      end
      exp_l = exp_l + 100;
    end
    n0 = pps_cnt;
    wait_until(exp_l + 250);
    checks++;
    if (pps_cnt !== n0 || missed_count_o !== 8'd4 || locked_o !== 1'b0) begin
      errors++; $display("FAIL hold_expired_quiet: extra_pulses=%0d miss=%0d lock=%b, required 0 4 0",
                         pps_cnt - n0, missed_count_o, locked_o);
    end
  endtask

  task automatic test_holdover_recover;
    int r;
    r = cyc + 2;
    gps_pulse_at(r);
    wait_until(r + 4);
    checks++;
    if (pps_o !== 1'b1 || missed_count_o !== 8'd0 || locked_o !== 1'b0) begin
      errors++; $display("FAIL reacq_first: pps=%b miss=%0d lock=%b, required 1 0 0", pps_o, missed_count_o, locked_o);
    end
    exp_l = r + 4;
    for (int k = 2; k <= LC; k++) begin
      gps_pulse_at(exp_l + 96);
      exp_l = exp_l + 100;
    end
    wait_until(exp_l);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b1) begin
      errors++; $display("FAIL reacq_lock: pps=%b lock=%b, required 1 1", pps_o, locked_o);
    end
    wait_until(exp_l + 104);
    exp_l = exp_l + 104;
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || holdover_o !== 1'b1 || missed_count_o !== 8'd2) begin
      errors++; $display("FAIL recov_two_miss: pps=%b hold=%b miss=%0d, required 1 1 2", pps_o, holdover_o, missed_count_o);
    end
    exp_l = exp_l + 100;
    gps_pulse_at(exp_l + 93);
    wait_until(exp_l + 97);
    checks++;
    if (pps_o !== 1'b1 || last_period_o !== 28'd97 || missed_count_o !== 8'd0 ||
        holdover_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL recov_edge97: pps=%b last=%0d miss=%0d hold=%b lock=%b, required 1 97 0 0 1",
                         pps_o, last_period_o, missed_count_o, holdover_o, locked_o);
    end
    exp_l = exp_l + 97;
  endtask

  task automatic test_edge_at_limit;
    gps_pulse_at(exp_l + 100);
    wait_until(exp_l + 103);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL limit_pre: pps=%b, required 0", pps_o); end
    wait_until(exp_l + 104);
    checks++;
    if (pps_o !== 1'b1 || last_period_o !== 28'd104 || holdover_o !== 1'b0 ||
        locked_o !== 1'b1 || missed_count_o !== 8'd0) begin
      errors++; $display("FAIL limit_edge: pps=%b last=%0d hold=%b lock=%b miss=%0d, required 1 104 0 1 0",
                         pps_o, last_period_o, holdover_o, locked_o, missed_count_o);
    end
    wait_until(exp_l + 105);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL limit_single: pps=%b, required 0", pps_o); end
    exp_l = exp_l + 104;
  endtask

  task automatic test_reset_mid_holdover;
    int r;
    int n0;
    wait_until(exp_l + 104);
    checks++;
    if (holdover_o !== 1'b1) begin errors++; $display("FAIL rst_pre_hold: hold=%b, required 1", holdover_o); end
    exp_l = exp_l + 104;
    wait_until(exp_l + 20);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pps_o, locked_o, holdover_o} !== 3'b000 || last_period_o !== 28'd0 ||
        missed_count_o !== 8'd0 || glitch_count_o !== 8'd0) begin
      errors++; $display("FAIL rst_async: pps=%b lock=%b hold=%b last=%0d miss=%0d glitch=%0d, required all 0",
                         pps_o, locked_o, holdover_o, last_period_o, missed_count_o, glitch_count_o);
    end
    n0 = pps_cnt;
    repeat (3) @(negedge clk250);
    rst_n = 1'b1;
    repeat (6) @(negedge clk250);
    checks++;
    if (pps_cnt !== n0) begin errors++; $display("FAIL rst_no_pps: pulses=%0d, required 0", pps_cnt - n0); end
    r = cyc + 2;
    gps_pulse_at(r);
    wait_until(r + 4);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b0 || holdover_o !== 1'b0) begin
      errors++; $display("FAIL rst_first_edge: pps=%b lock=%b hold=%b, required 1 0 0", pps_o, locked_o, holdover_o);
    end
    exp_l = r + 4;
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b0) begin
      errors++; $display("FAIL rst_g2: pps=%b lock=%b, required 1 0", pps_o, locked_o);
    end
    exp_l = exp_l + 100;
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || locked_o !== 1'b1) begin
      errors++; $display("FAIL rst_g3_lock: pps=%b lock=%b, required 1 1", pps_o, locked_o);
    end
    exp_l = exp_l + 100;
  endtask

  task automatic test_gps_mask;
    gps_en = 1'b0;
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b0 || glitch_count_o !== 8'd0) begin
      errors++; $display("FAIL mask_edge: pps=%b glitch=%0d, required 0 0", pps_o, glitch_count_o);
    end
    wait_until(exp_l + 104);
    checks++;
    if (pps_o !== 1'b1 || holdover_o !== 1'b1 || missed_count_o !== 8'd1) begin
      errors++; $display("FAIL mask_holdover: pps=%b hold=%b miss=%0d, required 1 1 1", pps_o, holdover_o, missed_count_o);
    end
    exp_l = exp_l + 104;
    gps_en = 1'b1;
    // Edge lands on the same cycle as the holdover synthetic pulse.
    gps_pulse_at(exp_l + 96);
    wait_until(exp_l + 100);
    checks++;
    if (pps_o !== 1'b1 || last_period_o !== 28'd100 || missed_count_o !== 8'd0 ||
        holdover_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL coincide: pps=%b last=%0d miss=%0d hold=%b lock=%b, required 1 100 0 0 1",
                         pps_o, last_period_o, missed_count_o, holdover_o, locked_o);
    end
    wait_until(exp_l + 101);
    checks++;
    if (pps_o !== 1'b0) begin errors++; $display("FAIL coincide_single: pps=%b, required 0", pps_o); end
    exp_l = exp_l + 100;
  endtask

  task automatic test_back_to_back;
    checks++;
    if (dbl_cnt !== 0) begin errors++; $display("FAIL back_to_back: doubles=%0d, required 0", dbl_cnt); end
  endtask

  initial begin
    test_reset;
    test_acquire_lock;
    test_glitch;
    test_holdover_expire;
    test_holdover_recover;
    test_edge_at_limit;
    test_reset_mid_holdover;
    test_gps_mask;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
